mips_regfile_mp: RTL

//   Parametrised register file for the single-cycle MIPS datapath. Two asynchronous

---
 rtl/mips_regfile_mp.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mips_regfile_mp.sv
// ============================================================================
// Module   : mips_regfile_mp
// Brief    : MIPS register file, two async read ports, general + link write
//            ports, r0 hardwired to zero, sequenced bulk-clear engine.
//            Optional macro MIPS_RF_BYPASS_EN enables write-through forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_regfile_mp #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int LINK_REG    = 31,
    parameter int LINK_OFFSET = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_pc,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int                DEPTH       = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_link_addr = ADDR_W'(LINK_REG);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_count;
    logic [ADDR_W-1:0]   w_count_nxt;
    logic                r_clr_done;
    logic                w_done_nxt;
    logic [DATA_W-1:0]   r_regs [DEPTH];

    logic                w_busy;
    logic                w_wr_fire;
    logic                w_link_fire;
    logic [DATA_W-1:0]   w_link_value;

    assign w_busy       = (r_state == ST_CLEAR);
    assign w_wr_fire    = wr_en && (wr_addr != '0) && !w_busy;
    // A link register of 0 would break the hardwired-zero guarantee.
    assign w_link_fire  = link_en && (c_link_addr != '0) && !w_busy;
    assign w_link_value = link_pc + DATA_W'(LINK_OFFSET);

    assign clr_busy = w_busy;
    assign clr_done = r_clr_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_clr_done <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_count_nxt = ADDR_W'(1);
                end
            end
            ST_CLEAR: begin
                // The counter parks on the last index instead of wrapping.
                if (r_count == c_last_addr) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_count_nxt = r_count + ADDR_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Link write is placed last so it wins over a general write to the same index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_busy) begin
            r_regs[r_count] <= '0;
        end else begin
            if (w_wr_fire) begin
                r_regs[wr_addr] <= wr_data;
            end
            if (w_link_fire) begin
                r_regs[c_link_addr] <= w_link_value;
            end
        end
    end

    always_comb begin
        rd_data_a = (rd_addr_a == '0) ? '0 : r_regs[rd_addr_a];
        rd_data_b = (rd_addr_b == '0) ? '0 : r_regs[rd_addr_b];
`ifdef MIPS_RF_BYPASS_EN
        if (rd_addr_a != '0) begin
            if (w_link_fire && (rd_addr_a == c_link_addr)) begin
                rd_data_a = w_link_value;
            end else if (w_wr_fire && (rd_addr_a == wr_addr)) begin
                rd_data_a = wr_data;
            end
        end
        if (rd_addr_b != '0) begin
            if (w_link_fire && (rd_addr_b == c_link_addr)) begin
                rd_data_b = w_link_value;
            end else if (w_wr_fire && (rd_addr_b == wr_addr)) begin
                rd_data_b = wr_data;
            end
        end
`endif
    end

endmodule

`default_nettype wire
